// File: rtl/bnn_layer_engine.sv
// bnn_layer_engine: parallel binary neurons over a chunked input vector.
// Each accepted beat adds the XNOR-popcount of the beat to a per-neuron
// accumulator. The final beat compares the total with a per-neuron threshold
// and hands the result to the downstream consumer over a ready/valid port.
module bnn_layer_engine #(
   parameter int CHUNK_W    = 16,
   parameter int NUM_CHUNKS = 4,
   parameter int NEURONS    = 8,
   parameter int ACC_W      = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CHUNK_W-1:0]         in_bits,
   input  logic                       in_last,
   input  logic [NEURONS*CHUNK_W-1:0] weights,
   input  logic [NEURONS*ACC_W-1:0]   thresholds,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NEURONS-1:0]         out_act,
   output logic [NEURONS*ACC_W-1:0]   out_popcount,
   output logic                       err_len
);

   localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam int PC_W  = $clog2(CHUNK_W + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_CHUNKS - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [CNT_W-1:0]  beat_cnt_reg;
   logic              err_len_reg;

   logic              accept;
   logic              beat_is_last;
   logic              vec_end;
   logic              good_last;
   logic              frame_err;

   // Count of ones in a chunk; the match vector is formed by the caller.
   function automatic logic [PC_W-1:0] popcnt(input logic [CHUNK_W-1:0] v);
      logic [PC_W-1:0] cnt;
      cnt = '0;
      for (int b = 0; b < CHUNK_W; b++) begin
         cnt = cnt + PC_W'(v[b]);
      end
      return cnt;
   endfunction

   // Upstream stalls only when a held result is not being taken this cycle.
   assign out_valid    = (state_reg == HOLD);
   assign in_ready     = !(out_valid && !out_ready);
   assign accept       = in_valid && in_ready;
   assign beat_is_last = (beat_cnt_reg == LAST_BEAT);
   // Any accepted beat that ends a vector, well-framed or not, clears the accumulators.
   assign vec_end      = accept && (in_last || beat_is_last);
   assign good_last    = accept && in_last && beat_is_last;
   assign frame_err    = accept && (in_last != beat_is_last);
   assign err_len      = err_len_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NEURONS; gi++) begin : g_neuron
         logic [CHUNK_W-1:0] match;
         logic [PC_W-1:0]    pc_cnt;
         logic [ACC_W-1:0]   total;
         logic [ACC_W-1:0]   acc_reg;
         logic [ACC_W-1:0]   pc_out_reg;
         logic               act_reg;

         assign match  = ~(in_bits ^ weights[gi*CHUNK_W +: CHUNK_W]);
         assign pc_cnt = popcnt(match);
         assign total  = acc_reg + ACC_W'(pc_cnt);

         // Accumulate mid-vector beats; any vector-ending beat restarts from zero.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               acc_reg <= '0;
            end else if (accept) begin
               acc_reg <= vec_end ? '0 : total;
            end
         end

         // Capture total and activation only on a well-framed final beat.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pc_out_reg <= '0;
               act_reg    <= 1'b0;
            end else if (good_last) begin
               pc_out_reg <= total;
               act_reg    <= (total >= thresholds[gi*ACC_W +: ACC_W]);
            end
         end

         assign out_popcount[gi*ACC_W +: ACC_W] = pc_out_reg;
         assign out_act[gi]                      = act_reg;
      end
   endgenerate

   // Beat position within the vector, framing error pulse and output state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ACCUM;
         beat_cnt_reg <= '0;
         err_len_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         err_len_reg <= frame_err;
         if (accept) begin
            beat_cnt_reg <= vec_end ? '0 : beat_cnt_reg + 1'b1;
         end
      end
   end

   // A new good result always (re)enters HOLD; otherwise HOLD drains on a handshake.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ACCUM: begin
            if (good_last) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (good_last) begin
               state_next = HOLD;
            end else if (out_ready) begin
               state_next = ACCUM;
            end
         end
         default: state_next = ACCUM;
      endcase
   end

endmodule

// File: tb/tb_bnn_layer_engine.sv
// Scoreboard testbench for bnn_layer_engine: expected results are queued when
// a vector's last beat is driven and compared at each output handshake.
module tb_bnn_layer_engine;

   localparam int CW = 16;
   localparam int NC = 4;
   localparam int NN = 8;
   localparam int AW = 8;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [CW-1:0]      in_bits = '0;
   logic               in_last = 1'b0;
   logic [NN*CW-1:0]   weights = '0;
   logic [NN*AW-1:0]   thresholds = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [NN-1:0]      out_act;
   logic [NN*AW-1:0]   out_popcount;
   logic               err_len;

   bnn_layer_engine #(
      .CHUNK_W(CW), .NUM_CHUNKS(NC), .NEURONS(NN), .ACC_W(AW)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
      .in_last(in_last), .weights(weights), .thresholds(thresholds),
      .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act),
      .out_popcount(out_popcount), .err_len(err_len)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NN-1:0]    act;
      logic [NN*AW-1:0] pc;
   } exp_t;

   exp_t            sb[$];
   int              hs_cyc[$];
   int              cyc = 0;
   int              checks = 0;
   int              errors = 0;
   exp_t            mon_e;
   exp_t            exp_a;

   logic [CW-1:0]    vb[NC];
   logic [NN*CW-1:0] vw[NC];
   logic [NN*AW-1:0] vt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: count positions where input bit equals weight bit, over all beats.
   function automatic exp_t model();
      exp_t e;
      for (int k = 0; k < NN; k++) begin
         int tot;
         tot = 0;
         for (int b = 0; b < NC; b++) begin
            for (int i = 0; i < CW; i++) begin
               if (vb[b][i] == vw[b][k*CW + i]) tot++;
            end
         end
         e.pc[k*AW +: AW] = AW'(tot);
         e.act[k]         = (tot >= int'(vt[k*AW +: AW]));
      end
      return e;
   endfunction

   task automatic rand_vec();
      for (int b = 0; b < NC; b++) begin
         vb[b] = CW'($urandom);
         vw[b] = {$urandom, $urandom, $urandom, $urandom};
      end
      for (int k = 0; k < NN; k++) begin
         vt[k*AW +: AW] = AW'($urandom_range(20, 44));
      end
   endtask

   task automatic drive(input logic [CW-1:0] b, input logic l, input logic [NN*CW-1:0] w);
      in_valid   = 1'b1;
      in_bits    = b;
      in_last    = l;
      weights    = w;
      thresholds = vt;
   endtask

   // Wait (bounded) for the beat to be accepted; returns 1 time unit after that edge.
   task automatic wait_accept();
      int n;
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         if (in_ready) break;
         n++;
      end
      if (n >= 50) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic send_vec(input bit push, input int first);
      for (int b = first; b < NC; b++) begin
         drive(vb[b], (b == NC - 1), vw[b]);
         if (push && b == NC - 1) sb.push_back(model());
         wait_accept();
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Output side of the scoreboard: compare on each handshake.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            $display("result cyc=%0d act=%02h pc=%016h", cyc, out_act, out_popcount);
            chk("out_act", 64'(out_act), 64'(mon_e.act));
            chk("out_pc", 64'(out_popcount), 64'(mon_e.pc));
         end
         hs_cyc.push_back(cyc);
      end
   end

   initial begin
      // Reset state
      vt = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_act", 64'(out_act), 64'd0);
      chk("rst_out_pc", 64'(out_popcount), 64'd0);
      chk("rst_err_len", 64'(err_len), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // All-match: every neuron reaches 64 and meets threshold 64
      for (int b = 0; b < NC; b++) begin
         vb[b] = '1;
         vw[b] = '1;
      end
      vt = {NN{8'd64}};
      send_vec(1'b1, 0);
      chk("t1_latency_valid", 64'(out_valid), 64'd1);
      chk("t1_act_direct", 64'(out_act), 64'hFF);
      idle();
      chk("t1_valid_drop", 64'(out_valid), 64'd0);

      // Mixed neurons
      for (int b = 0; b < NC; b++) begin
         vb[b] = 16'hFFFF;
         vw[b] = {{6{16'hFFFF}}, 16'hAAAA, 16'h0000};
      end
      vt = {{6{8'd65}}, 8'd32, 8'd1};
      send_vec(1'b1, 0);
      chk("t2_act_direct", 64'(out_act), 64'h02);
      idle();

      // Back-pressure: hold result A, present vector B
      out_ready = 1'b0;
      rand_vec();
      send_vec(1'b1, 0);
      exp_a = model();
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      rand_vec();
      drive(vb[0], 1'b0, vw[0]);
      repeat (3) begin
         @(negedge clk);
         chk("t3_in_ready_low", 64'(in_ready), 64'd0);
         chk("t3_valid_held", 64'(out_valid), 64'd1);
         chk("t3_pc_stable", 64'(out_popcount), 64'(exp_a.pc));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_accept();
      send_vec(1'b1, 1);
      chk("t3_b_latency", 64'(out_valid), 64'd1);
      idle();

      // Back-to-back: three vectors, continuous valid
      hs_cyc.delete();
      for (int v = 0; v < 3; v++) begin
         rand_vec();
         send_vec(1'b1, 0);
      end
      idle();
      idle();
      chk("t4_result_count", 64'(hs_cyc.size()), 64'd3);
      if (hs_cyc.size() == 3) begin
         chk("t4_spacing_1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd4);
         chk("t4_spacing_2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd4);
      end

      // Framing: early in_last
      rand_vec();
      drive(vb[0], 1'b0, vw[0]);
      wait_accept();
      drive(vb[1], 1'b1, vw[1]);
      wait_accept();
      chk("t5_early_err", 64'(err_len), 64'd1);
      chk("t5_early_noval", 64'(out_valid), 64'd0);
      idle();
      chk("t5_early_err_pulse", 64'(err_len), 64'd0);
      rand_vec();
      send_vec(1'b1, 0);
      idle();

      // Framing: missing in_last
      rand_vec();
      for (int b = 0; b < NC; b++) begin
         drive(vb[b], 1'b0, vw[b]);
         wait_accept();
      end
      chk("t5_late_err", 64'(err_len), 64'd1);
      chk("t5_late_noval", 64'(out_valid), 64'd0);
      idle();
      chk("t5_late_err_pulse", 64'(err_len), 64'd0);
      rand_vec();
      send_vec(1'b1, 0);
      idle();

      // Reset mid-vector
      rand_vec();
      send_vec(1'b0, 2);
      rand_vec();
      drive(vb[0], 1'b0, vw[0]);
      wait_accept();
      drive(vb[1], 1'b0, vw[1]);
      wait_accept();
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1 chk("t6_mid_rst_valid", 64'(out_valid), 64'd0);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      rand_vec();
      send_vec(1'b1, 0);
      idle();

      // Reset during HOLD
      out_ready = 1'b0;
      rand_vec();
      send_vec(1'b1, 0);
      chk("t6_hold_valid", 64'(out_valid), 64'd1);
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("t6_hold_rst_valid", 64'(out_valid), 64'd0);
      chk("t6_hold_rst_pc", 64'(out_popcount), 64'd0);
      chk("t6_hold_rst_ready", 64'(in_ready), 64'd1);
      sb.delete();
      #1 rst = 1'b0;
      out_ready = 1'b1;
      idle();
      idle();
      chk("t6_no_valid_after", 64'(out_valid), 64'd0);

      // Drain scoreboard
      for (int n = 0; n < 20; n++) begin
         if (sb.size() == 0) break;
         idle();
      end
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
